dt_param: RTL and testbench

Parametrised two-pass distance-transform engine: reads a packed binary image from the source ROM, writes one distance word per pixel into the result RAM, then runs a forward raster pass and a backward raster pass. Image size, distance width and the metric (chessboard or city-block) are configurable. Out-of-image neighbours are handled explicitly. It is the successor to the fixed 128×128 chessboard engine and sits between the same sti ROM and res RAM ports, adding a start/busy/done handshake.

---
 rtl/dt_pkg.sv | 46 ++++
 rtl/dt_scan_pass.sv | 99 +++++++++
 rtl/dt_param.sv | 185 ++++++++++++++++++
 tb/tb_dt_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - phase/neighbour types and arithmetic helpers for the dt_param distance-transform engine
package dt_pkg;

  typedef enum logic [2:0] {PH_IDLE, PH_LOAD, PH_FWD, PH_BWD, PH_DONE} dt_phase_e;
  typedef enum logic [2:0] {NB_NW, NB_N, NB_NE, NB_W, NB_E, NB_SW, NB_S, NB_SE} dt_nb_e;
  typedef logic [31:0] dt_word_t;

  localparam logic DT_MODE_CHESS = 1'b0;
  localparam logic DT_MODE_CITY  = 1'b1;
  localparam logic DT_DIR_FWD    = 1'b0;
  localparam logic DT_DIR_BWD    = 1'b1;

  function automatic dt_word_t sat_inc(input dt_word_t v, input dt_word_t maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

  function automatic dt_word_t dt_min(input dt_word_t a, input dt_word_t b);
    return (a < b) ? a : b;
  endfunction

  // Slot k of a pass maps straight onto the enum: forward uses NW..W, backward E..SE.
  function automatic dt_nb_e nb_sel(input logic bwd, input logic [1:0] k);
    return dt_nb_e'({bwd, k});
  endfunction

  function automatic logic nb_up(input dt_nb_e n);
    return n inside {NB_NW, NB_N, NB_NE};
  endfunction

  function automatic logic nb_down(input dt_nb_e n);
    return n inside {NB_SW, NB_S, NB_SE};
  endfunction

  function automatic logic nb_left(input dt_nb_e n);
    return n inside {NB_NW, NB_W, NB_SW};
  endfunction

  function automatic logic nb_right(input dt_nb_e n);
    return n inside {NB_NE, NB_E, NB_SE};
  endfunction

  function automatic logic nb_diag(input dt_nb_e n);
    return n inside {NB_NW, NB_NE, NB_SW, NB_SE};
  endfunction

endpackage

// File: rtl/dt_scan_pass.sv
// rtl/dt_scan_pass.sv - per-pixel neighbour read sequencer and min accumulator (city-block masking only with DT_MODE_SEL_EN)
module dt_scan_pass
  import dt_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DIST_W = 8,
  localparam int RA_W  = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dir,
`ifdef DT_MODE_SEL_EN
  input  logic              city,
`endif
  input  logic [RA_W-1:0]   pix,
  input  logic              start,
  input  logic [DIST_W-1:0] self_val,
  input  logic [DIST_W-1:0] res_di,
  output logic              nb_rd,
  output logic [RA_W-1:0]   nb_addr,
  output logic [DIST_W-1:0] result
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam dt_word_t MAXV = (dt_word_t'(1) << DIST_W) - dt_word_t'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  logic [3:0]        rem_q;
  logic [3:0]        mask;
  logic [DIST_W-1:0] acc_q;
  logic [DIST_W-1:0] self_q;
  logic [DIST_W-1:0] cur_min;
  logic              pend_q;
  logic [1:0]        sel;
  logic [RW-1:0]     row, nrow;
  logic [CW-1:0]     col, ncol;
  dt_nb_e            n_k, n_sel;
  dt_word_t          min_w, inc_w;

  always_comb begin
    row  = pix[RA_W-1:CW];
    col  = pix[CW-1:0];
    mask = '0;
    n_k  = NB_NW;
    // Edge neighbours are dropped from the mask: they cost no cycle and count as MAXV.
    for (int k = 0; k < 4; k++) begin
      n_k = nb_sel(dir, 2'(k));
      mask[k] = !(nb_up(n_k) && row == '0) && !(nb_down(n_k) && row == ROW_LAST) &&
                !(nb_left(n_k) && col == '0) && !(nb_right(n_k) && col == COL_LAST);
`ifdef DT_MODE_SEL_EN
      if (city && nb_diag(n_k)) mask[k] = 1'b0;
`endif
    end

    sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rem_q[k]) sel = 2'(k);
    end
    nb_rd = |rem_q;
    n_sel = nb_sel(dir, sel);
    nrow  = row;
    ncol  = col;
    if (nb_up(n_sel))    nrow = row - ROW_ONE;
    if (nb_down(n_sel))  nrow = row + ROW_ONE;
    if (nb_left(n_sel))  ncol = col - COL_ONE;
    if (nb_right(n_sel)) ncol = col + COL_ONE;
    nb_addr = nb_rd ? {nrow, ncol} : '0;

    // Data of the read issued last cycle is folded in combinationally so the write needs no extra cycle.
    min_w   = pend_q ? dt_min(dt_word_t'(acc_q), dt_word_t'(res_di)) : dt_word_t'(acc_q);
    cur_min = DIST_W'(min_w);
    inc_w   = sat_inc(min_w, MAXV);
    result  = DIST_W'((dir == DT_DIR_BWD) ? dt_min(dt_word_t'(self_q), inc_w) : inc_w);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      acc_q  <= '0;
      self_q <= '0;
      pend_q <= 1'b0;
    end else if (start) begin
      rem_q  <= mask;
      acc_q  <= DIST_W'(MAXV);
      self_q <= self_val;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= cur_min;
      pend_q <= nb_rd;
      if (nb_rd) rem_q[sel] <= 1'b0;
    end
  end

endmodule

// File: rtl/dt_param.sv
// rtl/dt_param.sv - two-pass distance-transform engine top: phase FSM, ROM load, RAM port mux; DT_MODE_SEL_EN adds the mode port
module dt_param
  import dt_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8,
  localparam int SA_W  = $clog2(IMG_W * IMG_H / STI_W),
  localparam int RA_W  = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef DT_MODE_SEL_EN
  input  logic              mode,
`endif
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [SA_W-1:0]   sti_addr,
  input  logic [STI_W-1:0]  sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RA_W-1:0]   res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int SB = $clog2(STI_W);
  localparam logic [RA_W-1:0] PIX_LAST = '1;
  localparam logic [RA_W-1:0] PIX_ONE  = RA_W'(1);

  typedef enum logic [1:0] {ST_A, ST_B, ST_C} dt_step_e;

  dt_phase_e         phase_q, phase_d;
  dt_step_e          step_q, step_d;
  logic [RA_W-1:0]   pix_q, pix_d;
  logic [STI_W-1:0]  shreg_q, shreg_d;
  logic              city_q, city_d;
  logic              sp_start, sp_rd, scan_dir;
  logic [RA_W-1:0]   sp_addr;
  logic [DIST_W-1:0] sp_result;
  logic              advance, pass_end;

  assign scan_dir = (phase_q == PH_BWD) ? DT_DIR_BWD : DT_DIR_FWD;

  dt_scan_pass #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DIST_W (DIST_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .dir      (scan_dir),
`ifdef DT_MODE_SEL_EN
    .city     (city_q),
`endif
    .pix      (pix_q),
    .start    (sp_start),
    .self_val (res_di),
    .res_di   (res_di),
    .nb_rd    (sp_rd),
    .nb_addr  (sp_addr),
    .result   (sp_result)
  );

  always_comb begin
    phase_d  = phase_q;
    step_d   = step_q;
    pix_d    = pix_q;
    shreg_d  = shreg_q;
    city_d   = city_q;
    busy     = phase_q inside {PH_LOAD, PH_FWD, PH_BWD};
    done     = (phase_q == PH_DONE);
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_addr = '0;
    res_do   = '0;
    sp_start = 1'b0;
    advance  = 1'b0;
    pass_end = (phase_q == PH_BWD) ? (pix_q == '0) : (pix_q == PIX_LAST);

    case (phase_q)
      PH_IDLE, PH_DONE: begin
        if (start) begin
          phase_d = PH_LOAD;
          step_d  = ST_A;
          pix_d   = '0;
`ifdef DT_MODE_SEL_EN
          city_d  = mode;
`else
          city_d  = DT_MODE_CHESS;
`endif
        end
      end
      PH_LOAD: begin
        case (step_q)
          ST_A: begin
            sti_rd   = 1'b1;
            sti_addr = pix_q[RA_W-1:SB];
            step_d   = ST_B;
          end
          ST_B: begin
            shreg_d = sti_di;
            step_d  = ST_C;
          end
          default: begin
            res_wr   = 1'b1;
            res_addr = pix_q;
            res_do   = DIST_W'(shreg_q[STI_W-1]);
            shreg_d  = shreg_q << 1;
            pix_d    = pix_q + PIX_ONE;
            if (pix_q[SB-1:0] == '1) begin
              step_d = ST_A;
              if (pix_q == PIX_LAST) begin
                phase_d = PH_FWD;
                pix_d   = '0;
              end
            end
          end
        endcase
      end
      PH_FWD, PH_BWD: begin
        case (step_q)
          ST_A: begin
            res_rd   = 1'b1;
            res_addr = pix_q;
            step_d   = ST_B;
          end
          ST_B: begin
            if (res_di == '0) begin
              advance = 1'b1;
            end else begin
              sp_start = 1'b1;
              step_d   = ST_C;
            end
          end
          default: begin
            if (sp_rd) begin
              res_rd   = 1'b1;
              res_addr = sp_addr;
            end else begin
              res_wr   = 1'b1;
              res_addr = pix_q;
              res_do   = sp_result;
              advance  = 1'b1;
            end
          end
        endcase
      end
      default: phase_d = PH_IDLE;
    endcase

    if (advance) begin
      step_d = ST_A;
      if (phase_q == PH_FWD) begin
        if (pass_end) phase_d = PH_BWD;
        else          pix_d   = pix_q + PIX_ONE;
      end else begin
        if (pass_end) phase_d = PH_DONE;
        else          pix_d   = pix_q - PIX_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      step_q  <= ST_A;
      pix_q   <= '0;
      shreg_q <= '0;
      city_q  <= DT_MODE_CHESS;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
      pix_q   <= pix_d;
      shreg_q <= shreg_d;
      city_q  <= city_d;
    end
  end

endmodule

// File: tb/tb_dt_param.sv
// tb/tb_dt_param.sv - scoreboard bench for dt_param on 8x8 images; city-block runs only with DT_MODE_SEL_EN
`timescale 1ns/1ps
module tb_dt_param;

  localparam int W = 8, H = 8, SW = 16, NPIX = 64, NWORD = 4, BUDGET = 5000;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, busy, done, sti_rd, res_rd, res_wr;
  logic [1:0] sti_addr;
  logic [15:0] sti_di;
  logic [5:0] res_addr;
  logic [7:0] res_do, res_di;
`ifdef DT_MODE_SEL_EN
  logic mode = 1'b0;
`endif
  logic start4 = 1'b0, busy4, done4, sti_rd4, res_rd4, res_wr4;
  logic [1:0] sti_addr4;
  logic [15:0] sti_di4;
  logic [5:0] res_addr4;
  logic [3:0] res_do4, res_di4;

  logic [15:0] rom [NWORD];
  logic [7:0] ram [NPIX];
  logic [3:0] ram4 [NPIX];
  bit img [NPIX];
  int sb_q[$];
  int n_cmp = 0, n_bad = 0;
  int proto_err = 0, done_rises = 0;
  logic done_prev = 1'b0;

  dt_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef DT_MODE_SEL_EN
    .mode(mode),
`endif
    .busy(busy), .done(done), .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
  );

  dt_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
`ifdef DT_MODE_SEL_EN
    .mode(1'b0),
`endif
    .busy(busy4), .done(done4), .sti_rd(sti_rd4), .sti_addr(sti_addr4), .sti_di(sti_di4),
    .res_rd(res_rd4), .res_wr(res_wr4), .res_addr(res_addr4), .res_do(res_do4), .res_di(res_di4)
  );

  always @(posedge clk) begin
    if (sti_rd)  sti_di  <= rom[sti_addr];
    if (res_rd)  res_di  <= ram[res_addr];
    if (res_wr)  ram[res_addr] <= res_do;
    if (sti_rd4) sti_di4 <= rom[sti_addr4];
    if (res_rd4) res_di4 <= ram4[res_addr4];
    if (res_wr4) ram4[res_addr4] <= res_do4;
  end

  always @(negedge clk) begin
    if (res_rd && res_wr) proto_err++;
    if (res_rd4 && res_wr4) proto_err++;
    if (!res_rd && !res_wr && (res_addr != 6'd0 || res_do != 8'd0)) proto_err++;
    if (!sti_rd && sti_addr != 2'd0) proto_err++;
    if (sti_rd && !busy) proto_err++;
    if (done && !done_prev) done_rises++;
    done_prev = done;
  end

  function automatic int exp_dist(int r, int c, bit city, int maxv);
    int best, d, dr, dc;
    best = maxv;
    if (!img[r*W+c]) return 0;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        if (!img[rr*W+cc]) begin
          dr = (r > rr) ? r - rr : rr - r;
          dc = (c > cc) ? c - cc : cc - c;
          d  = city ? dr + dc : ((dr > dc) ? dr : dc);
          if (d < best) best = d;
        end
    return best;
  endfunction

  function automatic int nb_count(int r, int c, bit bwd, bit city);
    int n;
    bit in_pass;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        in_pass = bwd ? (dr == 1 || (dr == 0 && dc == 1)) : (dr == -1 || (dr == 0 && dc == -1));
        if (in_pass && (!city || dr == 0 || dc == 0) &&
            r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) n++;
      end
    return n;
  endfunction

  function automatic int exp_cycles(bit city);
    int t;
    t = NWORD * (2 + SW);
    for (int a = 0; a < NPIX; a++)
      t += img[a] ? 6 + nb_count(a / W, a % W, 1'b0, city) + nb_count(a / W, a % W, 1'b1, city) : 4;
    return t;
  endfunction

  task automatic set_rect(input int r0, input int r1, input int c0, input int c1, input bit fill_all);
    for (int a = 0; a < NPIX; a++)
      img[a] = fill_all || ((a / W) >= r0 && (a / W) <= r1 && (a % W) >= c0 && (a % W) <= c1);
    for (int w = 0; w < NWORD; w++)
      for (int b = 0; b < SW; b++) rom[w][SW-1-b] = img[w*SW+b];
  endtask

  task automatic run_main(input bit city, input int extra_start, input string tag);
    int cyc, nbusy, exp_cyc, rises0, e;
    for (int a = 0; a < NPIX; a++) sb_q.push_back(exp_dist(a / W, a % W, city, 255));
    exp_cyc = exp_cycles(city);
    rises0  = done_rises;
`ifdef DT_MODE_SEL_EN
    mode = city;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef DT_MODE_SEL_EN
    mode = ~city;
`endif
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy); end
    cyc = 0; nbusy = 0;
    while (done !== 1'b1 && cyc < BUDGET) begin
      if (busy === 1'b1) nbusy++;
      start = (cyc == extra_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL %s done_timeout: got %b want 1 within %0d cycles", tag, done, BUDGET); end
    n_cmp++;
    if (nbusy != exp_cyc) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, nbusy, exp_cyc); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL %s done_hold: got done=%b busy=%b want 1/0", tag, done, busy); end
    n_cmp++;
    if (done_rises - rises0 != 1) begin n_bad++; $display("FAIL %s done_rises: got %0d want 1", tag, done_rises - rises0); end
    for (int a = 0; a < NPIX; a++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (ram[a] !== 8'(e)) begin n_bad++; $display("FAIL %s pix(%0d,%0d): got %0d want %0d", tag, a / W, a % W, ram[a], e); end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do} !== 21'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, res_rd, res_wr, busy4, done4, res_rd4, res_wr4} !== 8'd0) begin
      n_bad++; $display("FAIL idle_outputs: got %b want 0", {busy, done, res_rd, res_wr, busy4, done4, res_rd4, res_wr4});
    end
  endtask

  task automatic test_single;
    set_rect(3, 3, 3, 3, 1'b0);
    run_main(1'b0, -1, "single");
    n_cmp++;
    if (ram[27] !== 8'd1) begin n_bad++; $display("FAIL single_center: got %0d want 1", ram[27]); end
  endtask

  task automatic test_square;
    set_rect(2, 5, 2, 5, 1'b0);
    run_main(1'b0, -1, "square_chess");
    n_cmp++;
    if (ram[3*W+3] !== 8'd2 || ram[2*W+2] !== 8'd1) begin
      n_bad++; $display("FAIL square_chess_key: got inner=%0d corner=%0d want 2/1", ram[3*W+3], ram[2*W+2]);
    end
`ifdef DT_MODE_SEL_EN
    run_main(1'b1, -1, "square_city");
    n_cmp++;
    if (ram[4*W+4] !== 8'd2 || ram[5*W+5] !== 8'd1) begin
      n_bad++; $display("FAIL square_city_key: got inner=%0d corner=%0d want 2/1", ram[4*W+4], ram[5*W+5]);
    end
`endif
  endtask

  task automatic test_back_to_back;
    set_rect(0, 0, 7, 7, 1'b0);
    run_main(1'b0, -1, "edge_0_7");
    set_rect(7, 7, 0, 1, 1'b0);
    run_main(1'b0, -1, "edge_7_0");
  endtask

  task automatic test_saturation;
    int cyc, e;
    set_rect(0, 0, 0, 0, 1'b1);
    for (int a = 0; a < NPIX; a++) sb_q.push_back(exp_dist(a / W, a % W, 1'b0, 15));
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < BUDGET) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (done4 !== 1'b1) begin n_bad++; $display("FAIL sat_done_timeout: got %b want 1", done4); end
    for (int a = 0; a < NPIX; a++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (ram4[a] !== 4'(e)) begin n_bad++; $display("FAIL sat pix(%0d,%0d): got %0d want %0d", a / W, a % W, ram4[a], e); end
    end
  endtask

  task automatic test_reset_midrun;
    set_rect(2, 5, 2, 5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do} !== 21'd0) begin
      n_bad++; $display("FAIL midrun_reset_outputs: got %b want 0", {busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got busy=%b done=%b want 0/0", busy, done); end
    run_main(1'b0, 150, "restart");
  endtask

  task automatic test_protocol;
    n_cmp++;
    if (proto_err != 0) begin n_bad++; $display("FAIL strobe_protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_square();
    test_back_to_back();
    test_saturation();
    test_reset_midrun();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
